// File: rtl/noc_inject_arbiter_if.sv
// Local injection port bundle: requester flit/handshake lanes toward the arbiter
// and the single flit/credit link toward router port 0.
interface noc_inject_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DEST_WIDTH = 4,
  parameter int FLIT_WIDTH = 256
);
  logic [NUM_REQ-1:0][FLIT_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0][DEST_WIDTH-1:0] req_dest;
  logic [NUM_REQ-1:0]                 req_is_tail;
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [FLIT_WIDTH-1:0]              data_out;
  logic [DEST_WIDTH-1:0]              dest_out;
  logic                               is_tail_out;
  logic                               send_out;
  logic                               credit_in;

  modport slave (
    input  req_data, req_dest, req_is_tail, req_valid, credit_in,
    output req_ready, data_out, dest_out, is_tail_out, send_out
  );

  modport master (
    output req_data, req_dest, req_is_tail, req_valid, credit_in,
    input  req_ready, data_out, dest_out, is_tail_out, send_out
  );
endinterface

// File: rtl/noc_inject_arbiter.sv
// Round-robin, packet-locked arbiter sharing one credit-flow-controlled router injection port.
// Optional per-requester tail counters enabled by defining NOC_INJECT_PKT_COUNT_EN.
module noc_inject_arbiter #(
  parameter int NUM_REQ           = 4,
  parameter int DEST_WIDTH        = 4,
  parameter int FLIT_WIDTH        = 256,
  parameter int FLIT_BUFFER_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  noc_inject_arbiter_if.slave        bus
`ifdef NOC_INJECT_PKT_COUNT_EN
  ,
  output logic [NUM_REQ-1:0][15:0]   pkt_count
`endif
);
  localparam int CNT_W = $clog2(FLIT_BUFFER_DEPTH + 1);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FLIT_BUFFER_DEPTH);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_nxt, owner, owner_nxt, winner, sel;
  logic [CNT_W-1:0]   credit_cnt;
  logic               found, can_send, grant, accept, sel_tail;

  logic [FLIT_WIDTH-1:0] data_p1;
  logic [DEST_WIDTH-1:0] dest_p1;
  logic                  tail_p1;
  logic                  vld_p1;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    int idx;
    idx    = 0;
    winner = rr_ptr;
    found  = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(rr_ptr) + off) % NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
  end

  // A locked owner keeps ready on credits alone, so other valids never reach the port mid-packet.
  always_comb begin
    can_send      = (credit_cnt != '0);
    sel           = (state == LOCKED) ? owner : winner;
    grant         = rst_n && can_send && ((state == LOCKED) || found);
    accept        = grant && bus.req_valid[sel];
    sel_tail      = bus.req_is_tail[sel];
    bus.req_ready = '0;
    bus.req_ready[sel] = grant;

    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    if (accept) begin
      if (sel_tail) begin
        state_nxt = IDLE;
        rr_nxt    = wrap_inc(sel);
      end else if (state == IDLE) begin
        state_nxt = LOCKED;
        owner_nxt = sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      rr_ptr     <= '0;
      credit_cnt <= CNT_MAX;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_nxt;
      case ({accept, bus.credit_in})
        2'b10:   credit_cnt <= credit_cnt - 1'b1;
        2'b01:   if (credit_cnt != CNT_MAX) credit_cnt <= credit_cnt + 1'b1;
        default: credit_cnt <= credit_cnt;
      endcase
    end
  end

  // A credit with no flit outstanding means the router and this block disagree on buffer state.
  always @(posedge clk) begin
    if (rst_n) assert (!(bus.credit_in && !accept && credit_cnt == CNT_MAX));
  end

  // Stage p1: registered flit toward the router.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      dest_p1 <= '0;
      tail_p1 <= 1'b0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        data_p1 <= bus.req_data[sel];
        dest_p1 <= bus.req_dest[sel];
        tail_p1 <= sel_tail;
      end
    end
  end

  assign bus.send_out    = vld_p1;
  assign bus.data_out    = data_p1;
  assign bus.dest_out    = dest_p1;
  assign bus.is_tail_out = tail_p1;

`ifdef NOC_INJECT_PKT_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count <= '0;
    end else if (accept && sel_tail) begin
      pkt_count[sel] <= pkt_count[sel] + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Directed bench for noc_inject_arbiter: per-requester flit queues drive the port,
// an ordered scoreboard holds the flits the router must see.
module tb_noc_inject_arbiter;
  typedef struct packed {
    logic [255:0] data;
    logic [3:0]   dest;
    logic         tail;
  } flit_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef NOC_INJECT_PKT_COUNT_EN
  logic [3:0][15:0] pkt_count;
`endif

  noc_inject_arbiter_if #(.NUM_REQ(4), .DEST_WIDTH(4), .FLIT_WIDTH(256)) bus ();

  noc_inject_arbiter #(
    .NUM_REQ(4), .DEST_WIDTH(4), .FLIT_WIDTH(256), .FLIT_BUFFER_DEPTH(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef NOC_INJECT_PKT_COUNT_EN
    ,
    .pkt_count (pkt_count)
`endif
  );

  always #5 clk = ~clk;

  flit_t rq [4][$];
  flit_t sb [$];
  int n_assert = 0;
  int n_fail   = 0;

  function automatic flit_t mk(input logic [255:0] d, input logic [3:0] ds, input logic t);
    flit_t f;
    f.data = d;
    f.dest = ds;
    f.tail = t;
    return f;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (rq[i].size() != 0) begin
        bus.req_valid[i]   = 1'b1;
        bus.req_data[i]    = rq[i][0].data;
        bus.req_dest[i]    = rq[i][0].dest;
        bus.req_is_tail[i] = rq[i][0].tail;
      end else begin
        bus.req_valid[i]   = 1'b0;
        bus.req_data[i]    = '0;
        bus.req_dest[i]    = '0;
        bus.req_is_tail[i] = 1'b0;
      end
    end
  endtask

  task automatic offer(input int r, input flit_t f, input logic expect_out);
    rq[r].push_back(f);
    if (expect_out) sb.push_back(f);
  endtask

  // One clock: credit for this edge, check ready/send at negedge, retire accepted flits after the edge.
  task automatic step(input string tag, input logic [3:0] exp_rdy, input logic cred, input logic exp_send);
    logic [3:0] acc;
    flit_t e;
    bus.credit_in = cred;
    @(negedge clk);
    chk({tag, "_ready"}, 256'(bus.req_ready), 256'(exp_rdy));
    chk({tag, "_send"}, 256'(bus.send_out), 256'(exp_send));
    if (bus.send_out === 1'b1) begin
      if (sb.size() == 0) begin
        chk({tag, "_unexpected_flit"}, 256'(1), 256'(0));
      end else begin
        e = sb.pop_front();
        chk({tag, "_data"}, bus.data_out, e.data);
        chk({tag, "_dest"}, 256'(bus.dest_out), 256'(e.dest));
        chk({tag, "_tail"}, 256'(bus.is_tail_out), 256'(e.tail));
      end
    end
    acc = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    bus.credit_in = 1'b0;
    for (int i = 0; i < 4; i++) if (acc[i]) void'(rq[i].pop_front());
    drive();
  endtask

  initial begin
    bus.credit_in   = 1'b0;
    bus.req_valid   = 4'hF;
    bus.req_data    = '0;
    bus.req_dest    = '0;
    bus.req_is_tail = '0;

    // Reset held: ready suppressed even with every requester valid.
    #12;
    chk("rst_ready", 256'(bus.req_ready), 256'(0));
    chk("rst_send", 256'(bus.send_out), 256'(0));
    chk("rst_data", bus.data_out, 256'(0));
    chk("rst_dest", 256'(bus.dest_out), 256'(0));
`ifdef NOC_INJECT_PKT_COUNT_EN
    chk("rst_pkt_count", 256'(pkt_count), 256'(0));
`endif
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int k = 0; k < 3; k++) step("idle", 4'b0000, 1'b0, 1'b0);

    // Single-flit packet from requester 0.
    offer(0, mk(256'hA5, 4'd3, 1'b1), 1'b1);
    drive();
    step("single_acc", 4'b0001, 1'b0, 1'b0);
    step("single_out", 4'b0000, 1'b0, 1'b1);

    // Requesters 1 and 2 race with 3-flit packets; credits keep pace at count 1.
    for (int k = 0; k < 3; k++) begin
      offer(1, mk(256'h100 + 256'(k), 4'd5, k == 2), 1'b1);
    end
    for (int k = 0; k < 3; k++) begin
      offer(2, mk(256'h200 + 256'(k), 4'd6, k == 2), 1'b1);
    end
    drive();
    step("pkt1_f0", 4'b0010, 1'b1, 1'b0);
    step("pkt1_f1", 4'b0010, 1'b1, 1'b1);
    step("pkt1_f2", 4'b0010, 1'b1, 1'b1);
    step("pkt2_f0", 4'b0100, 1'b1, 1'b1);
    step("pkt2_f1", 4'b0100, 1'b1, 1'b1);
    step("pkt2_f2", 4'b0100, 1'b1, 1'b1);
    step("pkt2_out", 4'b0000, 1'b1, 1'b1);
    chk("pkts_drained", 256'(sb.size()), 256'(0));

    // Pointer now at 3: requester 3 beats requester 0.
    offer(3, mk(256'h33, 4'd1, 1'b1), 1'b1);
    offer(0, mk(256'h44, 4'd2, 1'b1), 1'b1);
    drive();
    step("rr_3", 4'b1000, 1'b0, 1'b0);
    step("rr_0", 4'b0001, 1'b0, 1'b1);
    step("rr_out", 4'b0000, 1'b1, 1'b1);
    step("rr_cred", 4'b0000, 1'b1, 1'b0);
    chk("rr_drained", 256'(sb.size()), 256'(0));

    // No credits returned: only the buffer depth worth of flits may leave.
    for (int k = 0; k < 4; k++) begin
      offer(0, mk(256'h500 + 256'(k), 4'd7, k == 3), 1'b1);
    end
    drive();
    step("stall_f0", 4'b0001, 1'b0, 1'b0);
    step("stall_f1", 4'b0001, 1'b0, 1'b1);
    step("stall_a", 4'b0000, 1'b0, 1'b1);
    step("stall_b", 4'b0000, 1'b0, 1'b0);
    step("stall_cred", 4'b0000, 1'b1, 1'b0);
    step("stall_f2", 4'b0001, 1'b0, 1'b0);
    step("stall_c", 4'b0000, 1'b1, 1'b1);
    step("stall_f3", 4'b0001, 1'b1, 1'b0);
    step("stall_out", 4'b0000, 1'b1, 1'b1);
    chk("stall_drained", 256'(sb.size()), 256'(0));

    // Lock on requester 3, then reset mid-packet.
    for (int k = 0; k < 3; k++) begin
      offer(3, mk(256'h700 + 256'(k), 4'd8, k == 2), k == 0);
    end
    drive();
    step("lock_f0", 4'b1000, 1'b0, 1'b0);
    offer(0, mk(256'h900, 4'd9, 1'b1), 1'b1);
    drive();
    step("lock_hold", 4'b1000, 1'b1, 1'b1);
    rst_n = 1'b0;
    rq[3].delete();
    offer(0, mk(256'h901, 4'd10, 1'b1), 1'b1);
    drive();
    #2;
    chk("midrst_ready", 256'(bus.req_ready), 256'(0));
    chk("midrst_send", 256'(bus.send_out), 256'(0));
`ifdef NOC_INJECT_PKT_COUNT_EN
    chk("midrst_pkt_count", 256'(pkt_count), 256'(0));
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("post_rst_g0", 4'b0001, 1'b0, 1'b0);
`ifdef NOC_INJECT_PKT_COUNT_EN
    chk("pkt_count_0", 256'(pkt_count[0]), 256'(1));
`endif
    step("post_rst_g1", 4'b0001, 1'b0, 1'b1);
    step("post_rst_out", 4'b0000, 1'b1, 1'b1);
    step("post_rst_cred", 4'b0000, 1'b1, 1'b0);
    chk("post_rst_drained", 256'(sb.size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
